// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- architectural integer register file for the CPU datapath.
//
// Two combinational read ports (rs/rt operands) and one write port that
// updates on the rising clock edge (writeback). With ZERO_REG=1, register 0
// always reads zero and ignores writes.
//
// Parameters
//   WIDTH     data width of each register
//   ADDR_W    address width; the file holds 2**ADDR_W registers
//   ZERO_REG  1: register 0 is hardwired to zero; 0: ordinary storage
//
// Ports
//   clk    in   1       system clock, rising-edge active
//   reset  in   1       synchronous, active-high; clears every register
//   we3    in   1       write enable, port 3
//   ra1    in   ADDR_W  read address, port 1
//   ra2    in   ADDR_W  read address, port 2
//   wa3    in   ADDR_W  write address, port 3
//   wd3    in   WIDTH   write data, port 3
//   rd1    out  WIDTH   read data, port 1 (combinational)
//   rd2    out  WIDTH   read data, port 2 (combinational)
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a same-cycle write to the address being
//                      read is forwarded straight to the read port
//                      (write-first). When undefined, reads show the stored
//                      value, so the old value is seen until the edge.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // A write to register 0 is dropped when it is hardwired.
  logic wr_en;
  assign wr_en = we3 && !(ZeroEn && (wa3 == '0));

  // Reset has priority over a write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa3] <= wd3;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding only applies when the write will actually land this edge.
  logic fwd_ok;
  assign fwd_ok = wr_en && !reset;

  always_comb begin
    rd1 = mem_q[ra1];
    if (fwd_ok && (wa3 == ra1)) rd1 = wd3;
    if (ZeroEn && (ra1 == '0))  rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (fwd_ok && (wa3 == ra2)) rd2 = wd3;
    if (ZeroEn && (ra2 == '0))  rd2 = '0;
  end
`else
  always_comb begin
    rd1 = mem_q[ra1];
    if (ZeroEn && (ra1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (ZeroEn && (ra2 == '0)) rd2 = '0;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  localparam bit ZR = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we3 = 1'b0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic [AW-1:0] wa3 = '0;
  logic [W-1:0]  wd3 = '0;
  logic [W-1:0]  rd1;
  logic [W-1:0]  rd2;

  int checks = 0;
  int errors = 0;

  // Reference contents of the architectural registers.
  logic [W-1:0] model [N];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk  (clk),
    .reset(reset),
    .we3  (we3),
    .ra1  (ra1),
    .ra2  (ra2),
    .wa3  (wa3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  // What a read port should show right now, given the inputs currently applied.
  function automatic logic [W-1:0] expect_rd(input logic [AW-1:0] ra);
    if (ZR && ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && !reset && wa3 == ra && !(ZR && wa3 == 0)) return wd3;
`endif
    return model[ra];
  endfunction

  task automatic check_reads(input string tag);
    logic [W-1:0] e1, e2;
    e1 = expect_rd(ra1);
    e2 = expect_rd(ra2);
    checks++;
    assert (rd1 === e1) else begin
      errors++;
      $error("FAIL %s rd1 ra1=%0d observed=%h expected=%h", tag, ra1, rd1, e1);
    end
    checks++;
    assert (rd2 === e2) else begin
      errors++;
      $error("FAIL %s rd2 ra2=%0d observed=%h expected=%h", tag, ra2, rd2, e2);
    end
  endtask

  // Apply inputs, check reads before the edge, clock once, update the model,
  // then check again with the same inputs still applied.
  task automatic cycle(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input string tag);
    reset = rst; we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) model[i] = '0;
    end else if (we && !(ZR && wa == 0)) begin
      model[wa] = wd;
    end
    #1;
    check_reads({tag, "_post"});
  endtask

  task automatic peek(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input string tag);
    reset = 1'b0; we3 = 1'b0; ra1 = a1; ra2 = a2;
    #1;
    check_reads(tag);
  endtask

  initial begin
    // Initial reset: contents unknown before the first edge, so no pre-edge check.
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) model[i] = '0;
    #1;
    reset = 1'b0;

    // 1. every register reads zero after reset
    for (int a = 0; a < N; a++) peek(AW'(a), AW'(N - 1 - a), "reset_sweep");

    // 2. write to r0 is discarded
    cycle(1'b0, 1'b1, 5'd0, 32'd12, 5'd0, 5'd0, "r0_write");
    peek(5'd0, 5'd0, "r0_read");

    // 3. write r3, then read on both ports
    cycle(1'b0, 1'b1, 5'd3, 32'd12, 5'd1, 5'd2, "r3_write");
    peek(5'd3, 5'b00011, "r3_read");

    // 4. we3=0 leaves r7 untouched, then we3=1 writes it
    cycle(1'b0, 1'b1, 5'd7, 32'h1111_2222, 5'd7, 5'd0, "r7_init");
    cycle(1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, "r7_nowe");
    cycle(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, "r7_we");

    // 5. read-during-write on r9
    cycle(1'b0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, "r9_init");
    cycle(1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, "r9_rdw");

    // 6. reset beats a same-edge write
    cycle(1'b0, 1'b1, 5'd4, 32'h77, 5'd4, 5'd7, "r4_init");
    cycle(1'b1, 1'b1, 5'd4, 32'h55, 5'd4, 5'd7, "reset_vs_write");
    peek(5'd4, 5'd9, "after_reset");

    // Fill the file with known values, then randomized traffic.
    for (int a = 1; a < N; a++) cycle(1'b0, 1'b1, AW'(a), $urandom, AW'(a), AW'(a - 1), "fill");
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] wa, a1, a2;
      logic rst;
      wa  = AW'($urandom_range(0, N - 1));
      a1  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, N - 1));
      a2  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, N - 1));
      rst = ($urandom_range(0, 59) == 0);
      cycle(rst, 1'($urandom_range(0, 1)), wa, $urandom, a1, a2, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
